// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: masks and prioritises timer, software and
// external sources, and holds a single trap request with its mcause until acked.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no trap outstanding; request when GIE and an enabled source pends
// REQ    | irq_req held high, irq_cause frozen, waiting for irq_ack
// ACTIVE | core is in the handler; new sources stay pending until mret
module irq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic        irq_en,
    input  logic        re,
    input  logic        we,
    input  logic [1:0]  irq_addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    input  logic        irq_ack,
    input  logic        mret
);

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_SW    = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        msie, mtie, meie;
    logic        gie, gie_nxt;
    logic        pgie, pgie_nxt;
    logic        msip;
    logic        ext_meta, ext_sync;
    logic [31:0] cause_q, cause_nxt;
    logic        req_q;
    logic        bus_wr;
    logic        fire;
    logic        active;
    logic [31:0] mie_word, mip_word;

    assign bus_wr   = irq_en && we;
    assign active   = (state == S_ACTIVE);
    assign mie_word = {20'b0, meie, 3'b0, mtie, 3'b0, msie, 3'b0};
    assign mip_word = {20'b0, ext_sync, 3'b0, timer_irq, 3'b0, msip, 3'b0};
    assign fire     = |(mip_word & mie_word);

    always_comb begin
        dout = 32'b0;
        if (irq_en && re) begin
            case (irq_addr)
                2'd0:    dout = mie_word;
                2'd1:    dout = mip_word;
                2'd2:    dout = {29'b0, active, pgie, gie};
                default: dout = {31'b0, msip};
            endcase
        end
    end

    // Bus write to GIE first, then FSM events override it.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        gie_nxt   = gie;
        pgie_nxt  = pgie;
        if (bus_wr && (irq_addr == 2'd2)) begin
            gie_nxt = din[0];
        end
        case (state)
            S_IDLE: begin
                if (gie && fire) begin
                    state_nxt = S_REQ;
                    if (ext_sync && meie) begin
                        cause_nxt = CAUSE_EXT;
                    end else if (msip && msie) begin
                        cause_nxt = CAUSE_SW;
                    end else begin
                        cause_nxt = CAUSE_TIMER;
                    end
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    pgie_nxt  = gie;
                    gie_nxt   = 1'b0;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (mret) begin
                    gie_nxt   = pgie;
                    pgie_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cause_q <= 32'b0;
            req_q   <= 1'b0;
            gie     <= 1'b0;
            pgie    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            req_q   <= (state_nxt == S_REQ);
            gie     <= gie_nxt;
            pgie    <= pgie_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msie <= 1'b0;
            mtie <= 1'b0;
            meie <= 1'b0;
            msip <= 1'b0;
        end else if (bus_wr) begin
            if (irq_addr == 2'd0) begin
                msie <= din[3];
                mtie <= din[7];
                meie <= din[11];
            end
            if (irq_addr == 2'd3) begin
                msip <= din[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_meta <= 1'b0;
            ext_sync <= 1'b0;
        end else begin
            ext_meta <= ext_irq;
            ext_sync <= ext_meta;
        end
    end

    assign irq_req   = req_q;
    assign irq_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each step applies a vector and compares outputs
// against hand-computed values.
module tb_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        timer_irq;
    logic        ext_irq;
    logic        irq_en;
    logic        re;
    logic        we;
    logic [1:0]  irq_addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic        irq_ack;
    logic        mret;

    int n_vec = 0;
    int n_err = 0;

    irq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .irq_en    (irq_en),
        .re        (re),
        .we        (we),
        .irq_addr  (irq_addr),
        .din       (din),
        .dout      (dout),
        .irq_req   (irq_req),
        .irq_cause (irq_cause),
        .irq_ack   (irq_ack),
        .mret      (mret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        irq_en   = 1'b1;
        we       = 1'b1;
        irq_addr = a;
        din      = d;
        tick();
        irq_en   = 1'b0;
        we       = 1'b0;
        din      = 32'b0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        irq_en   = 1'b1;
        re       = 1'b1;
        irq_addr = a;
        #1;
        chk(tag, dout, exp);
        irq_en   = 1'b0;
        re       = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        irq_en    = 1'b0;
        re        = 1'b0;
        we        = 1'b0;
        irq_addr  = 2'd0;
        din       = 32'b0;
        irq_ack   = 1'b0;
        mret      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_req", {31'b0, irq_req}, 32'h0);
        chk("rst_cause", irq_cause, 32'h0);
        chk("rst_dout_idle", dout, 32'h0);

        // Timer request and acknowledge
        bus_write(2'd0, 32'h0000_0080);
        bus_write(2'd2, 32'h0000_0001);
        chk("t1_no_req_yet", {31'b0, irq_req}, 32'h0);
        timer_irq = 1'b1;
        tick();
        chk("t1_req", {31'b0, irq_req}, 32'h1);
        chk("t1_cause", irq_cause, 32'h8000_0007);
        pulse_ack();
        chk("t1_req_after_ack", {31'b0, irq_req}, 32'h0);
        bus_read("t1_status_active", 2'd2, 32'h6);
        timer_irq = 1'b0;
        pulse_mret();
        bus_read("t1_status_after_mret", 2'd2, 32'h3);
        tick();
        chk("t1_no_rereq", {31'b0, irq_req}, 32'h0);

        // All three sources together: timer wins first, ext wins after return
        bus_write(2'd0, 32'h0000_0888);
        timer_irq = 1'b1;
        ext_irq   = 1'b1;
        bus_write(2'd3, 32'h0000_0001);
        chk("t2_req", {31'b0, irq_req}, 32'h1);
        chk("t2_cause_timer", irq_cause, 32'h8000_0007);
        tick();
        chk("t2_cause_held", irq_cause, 32'h8000_0007);
        bus_read("t2_mip_all", 2'd1, 32'h0000_0888);
        pulse_ack();
        pulse_mret();
        chk("t2_gap_after_mret", {31'b0, irq_req}, 32'h0);
        tick();
        chk("t2_req2", {31'b0, irq_req}, 32'h1);
        chk("t2_cause_ext", irq_cause, 32'h8000_000B);

        // Request is held through source drop and MIE clear
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        bus_write(2'd0, 32'h0000_0000);
        tick();
        chk("t3_req_held", {31'b0, irq_req}, 32'h1);
        chk("t3_cause_held", irq_cause, 32'h8000_000B);
        // GIE write coinciding with ack: FSM update wins
        irq_en   = 1'b1;
        we       = 1'b1;
        irq_addr = 2'd2;
        din      = 32'h0;
        pulse_ack();
        irq_en   = 1'b0;
        we       = 1'b0;
        chk("t3_req_dropped", {31'b0, irq_req}, 32'h0);
        bus_read("t3_status_ack_wins", 2'd2, 32'h6);

        // Software source held pending while ACTIVE
        bus_write(2'd0, 32'h0000_0008);
        tick();
        tick();
        chk("t4_no_req_active", {31'b0, irq_req}, 32'h0);
        // GIE write coinciding with mret: mret wins
        irq_en   = 1'b1;
        we       = 1'b1;
        irq_addr = 2'd2;
        din      = 32'h0;
        pulse_mret();
        irq_en   = 1'b0;
        we       = 1'b0;
        chk("t4_no_req_at_mret", {31'b0, irq_req}, 32'h0);
        bus_read("t4_status_mret_wins", 2'd2, 32'h3);
        tick();
        chk("t4_req_sw", {31'b0, irq_req}, 32'h1);
        chk("t4_cause_sw", irq_cause, 32'h8000_0003);

        // Asynchronous reset in REQ
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_req", {31'b0, irq_req}, 32'h0);
        chk("t5_async_cause", irq_cause, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        bus_read("t5_mie", 2'd0, 32'h0);
        bus_read("t5_mip", 2'd1, 32'h0);
        bus_read("t5_status", 2'd2, 32'h0);
        bus_read("t5_msip", 2'd3, 32'h0);

        // mret and ack in IDLE have no effect
        bus_write(2'd2, 32'h0000_0001);
        pulse_mret();
        bus_read("t6_status_mret_idle", 2'd2, 32'h1);
        pulse_ack();
        bus_read("t6_status_ack_idle", 2'd2, 32'h1);
        chk("t6_no_req", {31'b0, irq_req}, 32'h0);
        timer_irq = 1'b1;
        tick();
        bus_read("t6_mip_timer", 2'd1, 32'h0000_0080);
        chk("t6_masked_no_req", {31'b0, irq_req}, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read("t6_mip_ro", 2'd1, 32'h0000_0080);
        timer_irq = 1'b0;
        bus_write(2'd0, 32'hFFFF_F777);
        bus_read("t6_mie_masked", 2'd0, 32'h0);
        bus_write(2'd3, 32'hFFFF_FFFE);
        bus_read("t6_msip_bit0", 2'd3, 32'h0);
        irq_en   = 1'b1;
        re       = 1'b0;
        irq_addr = 2'd2;
        #1;
        chk("t6_dout_no_re", dout, 32'h0);
        irq_en   = 1'b0;

        // External source latency: two sync edges plus one FSM edge
        bus_write(2'd0, 32'h0000_0800);
        ext_irq = 1'b1;
        tick();
        chk("t7_ext_edge1", {31'b0, irq_req}, 32'h0);
        tick();
        chk("t7_ext_edge2", {31'b0, irq_req}, 32'h0);
        tick();
        chk("t7_ext_edge3", {31'b0, irq_req}, 32'h1);
        chk("t7_ext_cause", irq_cause, 32'h8000_000B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
